// File: rtl/player_life_ctrl.sv
// player_life_ctrl: owns the player's life count and the post-spawn / post-hit
// immunity window. The window blinks the sprite and masks collisions. A held
// ball contact costs exactly one life, and present pickups add lives up to a ceiling.
module player_life_ctrl #(
  parameter int LIVES_INIT    = 3,
  parameter int LIVES_MAX     = 5,
  parameter int LIVES_W       = 3,
  parameter int IMMUNE_FRAMES = 120,
  parameter int BLINK_FRAMES  = 8,
  parameter int FRAME_CNT_W   = 8
) (
  input  logic               clk,
  input  logic               resetN,
  input  logic               startOfFrame,
  input  logic               newGame,
  input  logic               col_player_ball,
  input  logic               col_present,
  output logic               immortal,
  output logic               playerVisible,
  output logic [LIVES_W-1:0] lives,
  output logic               playerHit,
  output logic               lifeGained,
  output logic               gameOver
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_IMMUNE = 2'd1,
    ST_ALIVE  = 2'd2,
    ST_OVER   = 2'd3
  } state_t;

  localparam logic [LIVES_W-1:0]     LIVES_INIT_C = LIVES_W'(LIVES_INIT);
  localparam logic [LIVES_W-1:0]     LIVES_MAX_C  = LIVES_W'(LIVES_MAX);
  localparam logic [LIVES_W-1:0]     LIVES_ONE_C  = LIVES_W'(1);
  localparam logic [LIVES_W-1:0]     LIVES_ZERO_C = LIVES_W'(0);
  localparam logic [FRAME_CNT_W-1:0] IMM_LOAD_C   = FRAME_CNT_W'(IMMUNE_FRAMES);
  localparam logic [FRAME_CNT_W-1:0] BLINK_C      = FRAME_CNT_W'(BLINK_FRAMES);
  localparam logic [FRAME_CNT_W-1:0] CNT_ONE_C    = FRAME_CNT_W'(1);
  localparam logic [FRAME_CNT_W-1:0] CNT_ZERO_C   = FRAME_CNT_W'(0);

  state_t                 state_r;
  logic [FRAME_CNT_W-1:0] imm_cnt_r;
  logic [FRAME_CNT_W-1:0] blink_cnt_r;
  logic                   present_q_r;
  logic [LIVES_W-1:0]     lives_r;
  logic                   immortal_r;
  logic                   visible_r;
  logic                   hit_r;
  logic                   gained_r;
  logic                   over_r;

  logic                   present_rise_s;
  logic                   can_gain_s;
  logic [FRAME_CNT_W-1:0] blink_next_s;

  // Pickup edge detection, saturation test and next blink count
  always_comb begin
    present_rise_s = col_present & ~present_q_r;
    can_gain_s     = (lives_r < LIVES_MAX_C);
    blink_next_s   = blink_cnt_r + CNT_ONE_C;
  end

  // Life/immunity state machine with all outputs registered
  always_ff @(posedge clk or posedge resetN) begin
    if (resetN) begin
      state_r     <= ST_IDLE;
      imm_cnt_r   <= CNT_ZERO_C;
      blink_cnt_r <= CNT_ZERO_C;
      present_q_r <= 1'b0;
      lives_r     <= LIVES_ZERO_C;
      immortal_r  <= 1'b1;
      visible_r   <= 1'b0;
      hit_r       <= 1'b0;
      gained_r    <= 1'b0;
      over_r      <= 1'b0;
    end else begin
      present_q_r <= col_present;
      hit_r       <= 1'b0;
      gained_r    <= 1'b0;
      if (newGame) begin
        // A new game beats every other event in the same cycle
        lives_r     <= LIVES_INIT_C;
        over_r      <= 1'b0;
        state_r     <= ST_IMMUNE;
        imm_cnt_r   <= IMM_LOAD_C;
        blink_cnt_r <= CNT_ZERO_C;
        visible_r   <= 1'b1;
        immortal_r  <= 1'b1;
      end else begin
        case (state_r)
          ST_IDLE: begin
            immortal_r <= 1'b1;
            visible_r  <= 1'b0;
          end
          ST_IMMUNE: begin
            if (present_rise_s && can_gain_s) begin
              lives_r  <= lives_r + LIVES_ONE_C;
              gained_r <= 1'b1;
            end else begin
              lives_r  <= lives_r;
            end
            if (startOfFrame) begin
              if (imm_cnt_r == CNT_ONE_C) begin
                // Last immune frame: the player becomes vulnerable and steady
                state_r     <= ST_ALIVE;
                imm_cnt_r   <= CNT_ZERO_C;
                blink_cnt_r <= CNT_ZERO_C;
                visible_r   <= 1'b1;
                immortal_r  <= 1'b0;
              end else begin
                imm_cnt_r <= imm_cnt_r - CNT_ONE_C;
                if (blink_next_s == BLINK_C) begin
                  blink_cnt_r <= CNT_ZERO_C;
                  visible_r   <= ~visible_r;
                end else begin
                  blink_cnt_r <= blink_next_s;
                end
              end
            end else begin
              imm_cnt_r <= imm_cnt_r;
            end
          end
          ST_ALIVE: begin
            if (col_player_ball) begin
              hit_r <= 1'b1;
              if (present_rise_s && can_gain_s) begin
                // Hit and pickup cancel out; saturation judged on pre-hit lives
                gained_r    <= 1'b1;
                state_r     <= ST_IMMUNE;
                imm_cnt_r   <= IMM_LOAD_C;
                blink_cnt_r <= CNT_ZERO_C;
                visible_r   <= 1'b1;
                immortal_r  <= 1'b1;
              end else if (lives_r == LIVES_ONE_C) begin
                lives_r    <= LIVES_ZERO_C;
                state_r    <= ST_OVER;
                over_r     <= 1'b1;
                visible_r  <= 1'b0;
                immortal_r <= 1'b1;
              end else begin
                lives_r     <= lives_r - LIVES_ONE_C;
                state_r     <= ST_IMMUNE;
                imm_cnt_r   <= IMM_LOAD_C;
                blink_cnt_r <= CNT_ZERO_C;
                visible_r   <= 1'b1;
                immortal_r  <= 1'b1;
              end
            end else if (present_rise_s && can_gain_s) begin
              lives_r  <= lives_r + LIVES_ONE_C;
              gained_r <= 1'b1;
            end else begin
              lives_r <= lives_r;
            end
          end
          ST_OVER: begin
            lives_r    <= LIVES_ZERO_C;
            over_r     <= 1'b1;
            visible_r  <= 1'b0;
            immortal_r <= 1'b1;
          end
          default: begin
            state_r    <= ST_IDLE;
            immortal_r <= 1'b1;
            visible_r  <= 1'b0;
          end
        endcase
      end
    end
  end

  // Drive ports straight from the registers
  always_comb begin
    immortal      = immortal_r;
    playerVisible = visible_r;
    lives         = lives_r;
    playerHit     = hit_r;
    lifeGained    = gained_r;
    gameOver      = over_r;
  end

endmodule

// File: tb/tb_player_life_ctrl.sv
// Directed testbench for player_life_ctrl with hand-computed expectations.
module tb_player_life_ctrl;

  logic       clk = 1'b0;
  logic       resetN = 1'b1;
  logic       startOfFrame = 1'b0;
  logic       newGame = 1'b0;
  logic       col_player_ball = 1'b0;
  logic       col_present = 1'b0;
  logic       immortal;
  logic       playerVisible;
  logic [2:0] lives;
  logic       playerHit;
  logic       lifeGained;
  logic       gameOver;

  int n_checks = 0;
  int n_fail   = 0;
  int cnt;

  player_life_ctrl dut (
    .clk             (clk),
    .resetN          (resetN),
    .startOfFrame    (startOfFrame),
    .newGame         (newGame),
    .col_player_ball (col_player_ball),
    .col_present     (col_present),
    .immortal        (immortal),
    .playerVisible   (playerVisible),
    .lives           (lives),
    .playerHit       (playerHit),
    .lifeGained      (lifeGained),
    .gameOver        (gameOver)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // one clock edge, then settle so outputs are sampled away from the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // one startOfFrame pulse followed by one idle cycle
  task automatic frame();
    startOfFrame = 1'b1;
    tick();
    startOfFrame = 1'b0;
    tick();
  endtask

  task automatic frames(input int n);
    for (int i = 0; i < n; i++) frame();
  endtask

  task automatic start_game();
    newGame = 1'b1;
    tick();
    newGame = 1'b0;
  endtask

  // single-cycle ball contact, then sit out the full immunity window
  task automatic hit_and_recover();
    col_player_ball = 1'b1;
    tick();
    col_player_ball = 1'b0;
    frames(120);
  endtask

  initial begin
    // ---- 1: reset values, spawn immunity and blink
    tick();
    tick();
    check("rst_lives", lives, 0);
    check("rst_immortal", immortal, 1);
    check("rst_visible", playerVisible, 0);
    check("rst_gameover", gameOver, 0);
    check("rst_hit", playerHit, 0);
    check("rst_gained", lifeGained, 0);
    resetN = 1'b0;
    tick();
    check("idle_lives", lives, 0);
    start_game();
    check("ng_lives", lives, 3);
    check("ng_immortal", immortal, 1);
    check("ng_visible", playerVisible, 1);
    frames(7);
    check("blink7_visible", playerVisible, 1);
    frame();
    check("blink8_visible", playerVisible, 0);
    frames(8);
    check("blink16_visible", playerVisible, 1);
    frames(103);
    check("f119_immortal", immortal, 1);
    frame();
    check("f120_immortal", immortal, 0);
    check("f120_visible", playerVisible, 1);

    // ---- 2: held ball contact costs exactly one life
    col_player_ball = 1'b1;
    tick();
    check("hold_hit", playerHit, 1);
    check("hold_lives", lives, 2);
    check("hold_immortal", immortal, 1);
    cnt = 0;
    for (int i = 0; i < 49; i++) begin
      tick();
      cnt += playerHit;
    end
    check("hold_extra_hits", cnt, 0);
    frames(119);
    check("hold_f119_lives", lives, 2);
    check("hold_f119_immortal", immortal, 1);
    col_player_ball = 1'b0;
    frame();
    check("hold_f120_immortal", immortal, 0);

    // ---- 3: run out of lives
    hit_and_recover();
    check("l1_lives", lives, 1);
    check("l1_immortal", immortal, 0);
    col_player_ball = 1'b1;
    tick();
    col_player_ball = 1'b0;
    check("over_lives", lives, 0);
    check("over_flag", gameOver, 1);
    check("over_visible", playerVisible, 0);
    check("over_immortal", immortal, 1);
    col_player_ball = 1'b1;
    col_present = 1'b1;
    tick();
    tick();
    col_player_ball = 1'b0;
    col_present = 1'b0;
    tick();
    check("over_hold_lives", lives, 0);
    check("over_hold_flag", gameOver, 1);
    check("over_no_gain", lifeGained, 0);

    // ---- 4: life pickups with saturation
    start_game();
    check("ng2_flag", gameOver, 0);
    frames(120);
    cnt = 0;
    col_present = 1'b1;
    tick();
    cnt += lifeGained;
    check("pick1_lives", lives, 4);
    check("pick1_gained", lifeGained, 1);
    for (int i = 0; i < 3; i++) begin
      tick();
      cnt += lifeGained;
    end
    check("pick_held_lives", lives, 4);
    col_present = 1'b0;
    tick();
    col_present = 1'b1;
    tick();
    cnt += lifeGained;
    check("pick2_lives", lives, 5);
    col_present = 1'b0;
    tick();
    col_present = 1'b1;
    tick();
    cnt += lifeGained;
    check("pick3_lives", lives, 5);
    check("pick3_gained", lifeGained, 0);
    col_present = 1'b0;
    tick();
    check("pick_pulses", cnt, 2);

    // ---- 5: hit plus pickup at one life
    for (int i = 0; i < 4; i++) hit_and_recover();
    check("one_life", lives, 1);
    col_player_ball = 1'b1;
    col_present = 1'b1;
    tick();
    col_player_ball = 1'b0;
    col_present = 1'b0;
    check("both_lives", lives, 1);
    check("both_hit", playerHit, 1);
    check("both_gained", lifeGained, 1);
    check("both_immortal", immortal, 1);
    check("both_flag", gameOver, 0);
    tick();
    check("both_hit_clear", playerHit, 0);

    // ---- 6: asynchronous reset mid-immunity
    start_game();
    frames(120);
    hit_and_recover();
    check("pre6_lives", lives, 2);
    col_player_ball = 1'b1;
    tick();
    col_player_ball = 1'b0;
    frames(10);
    check("mid_imm_immortal", immortal, 1);
    #2;
    resetN = 1'b1;
    #1;
    check("arst_lives", lives, 0);
    check("arst_immortal", immortal, 1);
    check("arst_visible", playerVisible, 0);
    tick();
    resetN = 1'b0;
    tick();
    start_game();
    check("post_rst_lives", lives, 3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
